// File: rtl/ps2_pkg.sv
`default_nettype none
// ==== ps2_pkg : PS/2 host state encoding, timing defaults, command bytes ====
// ==== rev 1.0                                                            ====
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int unsigned DEF_INHIBIT_CYCLES = 10000;
  localparam int unsigned DEF_START_TIMEOUT  = 1500000;
  localparam int unsigned DEF_FRAME_TIMEOUT  = 200000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ==== ps2_sync_edge : PS/2 clock/data synchronizers + clock falling-edge detect ====
// ==== rev 1.0                                                                  ====
module ps2_sync_edge (
  input  logic clk,
  input  logic nrst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;

  // Idle-high reset so an undriven bus never looks like an edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign clk_fall = clk_sync[1] & ~clk_sync[0];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ==== ps2_host_tx : PS/2 host-to-device command transmitter (inhibit, RTS, frame, ACK) ====
// ==== rev 1.0                                                                          ====
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int unsigned FRAME_TIMEOUT  = DEF_FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] START_LAST   = 21'(START_TIMEOUT - 1);
  localparam logic [20:0] FRAME_LAST   = 21'(FRAME_TIMEOUT - 1);

  ps2_tx_state_t state, state_nx;
  logic [20:0]   tmo_cnt, tmo_cnt_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic          parity, parity_nx;
  logic          bit_low, bit_low_nx;
  logic          done_nx, error_nx;
  logic          clk_s, data_s, clk_fall;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .nrst     (nrst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      bit_low  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_nx;
      tmo_cnt  <= tmo_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      parity   <= parity_nx;
      bit_low  <= bit_low_nx;
      tx_done  <= done_nx;
      tx_error <= error_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tmo_cnt_nx = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 21'd1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    parity_nx  = parity;
    bit_low_nx = bit_low;
    done_nx    = 1'b0;
    error_nx   = 1'b0;

    case (state)
      ST_IDLE: begin
        tmo_cnt_nx = tmo_cnt;
        if (tx_start) begin
          shift_nx   = tx_data;
          parity_nx  = odd_parity(tx_data);
          tmo_cnt_nx = '0;
          bit_cnt_nx = '0;
          bit_low_nx = 1'b0;
          state_nx   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (tmo_cnt == INHIBIT_LAST) begin
          tmo_cnt_nx = '0;
          state_nx   = ST_REQ;
        end
      end

      // First device edge already asks for data bit 0; the frame timer starts here.
      ST_REQ: begin
        if (clk_fall) begin
          tmo_cnt_nx = '0;
          bit_cnt_nx = 4'd1;
          bit_low_nx = ~shift[0];
          shift_nx   = {1'b0, shift[7:1]};
          state_nx   = ST_DATA;
        end else if (tmo_cnt == START_LAST) begin
          error_nx = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (clk_fall) begin
          bit_cnt_nx = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            bit_low_nx = ~shift[0];
            shift_nx   = {1'b0, shift[7:1]};
          end else if (bit_cnt == 4'd8) begin
            bit_low_nx = ~parity;
          end else begin
            bit_low_nx = 1'b0;
            state_nx   = ST_ACK;
          end
        end else if (tmo_cnt == FRAME_LAST) begin
          error_nx = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          if (!data_s) begin
            state_nx = ST_WAIT_IDLE;
          end else begin
            error_nx = 1'b1;
            state_nx = ST_IDLE;
          end
        end else if (tmo_cnt == FRAME_LAST) begin
          error_nx = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else if (tmo_cnt == FRAME_LAST) begin
          error_nx = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // Decoded from state so reset releases the bus without waiting for a clock.
  assign ps2_clk_drive_low  = (state == ST_INHIBIT);
  assign ps2_data_drive_low = (state == ST_REQ) || ((state == ST_DATA) && bit_low);
  assign busy               = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ==== tb_ps2_host_tx : PS/2 device model + scoreboard bench for ps2_host_tx ====
// ==== rev 1.0                                                              ====
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 40;
  localparam int START = 300;
  localparam int FRAME = 3000;
  localparam int HP    = 25;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  exp_t        exp_q[$];
  logic [10:0] dev_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;

  assign clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
  assign data_line = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (START),
    .FRAME_TIMEOUT  (FRAME)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .tx_data            (tx_data),
    .tx_start           (tx_start),
    .ps2_clk            (clk_line),
    .ps2_data           (data_line),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low),
    .busy               (busy),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: time %0t reached, limit 5000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame a device should see: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones   = ones + int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Scoreboard monitor: every done/error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && (tx_done || tx_error)) begin
      check("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
      check("release_on_pulse", {29'd0, ps2_clk_drive_low, ps2_data_drive_low, busy}, 32'd0);
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("outcome_is_done", 32'(tx_done), 32'(mon_e.is_done));
        if (mon_e.is_done) begin
          check("device_frame_present", 32'(dev_q.size() != 0), 32'd1);
          if (dev_q.size() != 0)
            check("device_frame", 32'(dev_q.pop_front()), 32'(ref_frame(mon_e.data)));
        end
      end
    end
  end

  // mode 0: ACK, mode 1: NACK, mode 2: assert reset after the 5th falling edge.
  task automatic device_xfer(input logic [7:0] b, input int mode);
    logic [10:0] fr;
    int t;
    fr = '0;
    t  = 0;
    while (!(clk_line && !data_line) && t < 4*INH) begin
      cycles(1);
      t++;
    end
    check("rts_seen", 32'(t < 4*INH), 32'd1);
    if (t >= 4*INH) return;
    fr[0] = data_line;
    cycles(10);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (mode == 2 && k == 5) begin
        cycles(6);
        check("pre_reset_data_drive", 32'(ps2_data_drive_low), 32'd1);
        nrst = 1'b0;
        #1;
        check("reset_outputs_mid_frame",
              {27'd0, ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error}, 32'd0);
        cycles(3);
        dev_clk_low = 1'b0;
        cycles(2);
        nrst = 1'b1;
        cycles(2);
        check("idle_after_reset", 32'(busy), 32'd0);
        return;
      end
      cycles(HP);
      dev_clk_low = 1'b0;
      cycles(4);
      fr[k] = data_line;
      cycles(HP - 4);
    end
    if (mode == 0) dev_q.push_back(fr);
    else check("nack_frame", 32'(fr), 32'(ref_frame(b)));
    if (mode == 0) dev_data_low = 1'b1;
    cycles(5);
    dev_clk_low = 1'b1;
    cycles(HP);
    dev_clk_low = 1'b0;
    cycles(HP/2);
    dev_data_low = 1'b0;
  endtask

  task automatic issue(input logic [7:0] b, input bit push, input bit is_done);
    exp_t e;
    int t;
    t = 0;
    while (busy && t < 4*FRAME) begin
      cycles(1);
      t++;
    end
    tx_data  = b;
    tx_start = 1'b1;
    if (push) begin
      e.is_done = is_done;
      e.data    = b;
      exp_q.push_back(e);
    end
    cycles(1);
    tx_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic measure_inhibit(input string name);
    int n;
    n = 0;
    while (ps2_clk_drive_low && n < INH + 10) begin
      n++;
      cycles(1);
    end
    check(name, n, INH);
  endtask

  task automatic run_xfer(input logic [7:0] b, input int mode, input bit inject);
    int t;
    issue(b, mode != 2, mode == 0);
    measure_inhibit("inhibit_cycles");
    fork
      device_xfer(b, mode);
      if (inject) begin
        cycles(8*HP);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        check("busy_during_inject", 32'(busy), 32'd1);
      end
    join
    t = 0;
    while (busy && t < 4*FRAME) begin
      cycles(1);
      t++;
    end
    check("returned_idle", 32'(t < 4*FRAME), 32'd1);
    cycles(3);
  endtask

  task automatic run_timeout(input logic [7:0] b);
    int n;
    issue(b, 1'b1, 1'b0);
    measure_inhibit("timeout_inhibit_cycles");
    check("req_start_bit_driven", 32'(ps2_data_drive_low), 32'd1);
    n = 0;
    while (!tx_error && n < START + 50) begin
      n++;
      cycles(1);
    end
    check("start_timeout_cycles", n, START);
    cycles(2);
    check("timeout_lines_released", {29'd0, clk_line, data_line, busy}, 32'b110);
  endtask

  initial begin
    nrst = 1'b0;
    cycles(3);
    check("reset_outputs",
          {27'd0, ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error}, 32'd0);
    nrst = 1'b1;
    cycles(3);
    check("idle_outputs",
          {27'd0, ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error}, 32'd0);

    run_xfer(CMD_SET_LEDS, 0, 1'b0);
    run_xfer(8'h00, 0, 1'b0);
    run_xfer(CMD_RESET, 1, 1'b0);
    run_timeout(8'h3C);
    run_xfer(CMD_SET_LEDS, 0, 1'b1);
    run_xfer(8'hA3, 2, 1'b0);
    run_xfer(CMD_ACK, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_xfer(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);

    cycles(5);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("device_queue_drained", dev_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
